fp_normalizer_seq: RTL
======================

Name: fp_normalizer_seq

Overview:
- Multi-cycle, parametrised mantissa normaliser for the FP add/sub datapath. It sits between the mantissa adder and the rounding stage.
- Accepts a raw sum that may carry out or have leading zeros. Returns a normalised mantissa and adjusted exponent over a valid/ready handshake.
- Generalises the single-cycle leading-one normaliser with:
  - configurable widths and shift-per-cycle;
  - carry-out right-shift;
  - exponent overflow to infinity;
  - graceful underflow to a denormal;
  - status flags.

Parameters:
MANT_W, 24, mantissa width including hidden bit (min 4)
EXP_W, 8, biased exponent width (min 3)
STEP, 4, maximum left-shift positions per cycle (1..MANT_W)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_mant  input  MANT_W+1  raw mantissa; bit MANT_W is adder carry-out
in_exp  input  EXP_W  biased exponent of raw result
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_mant  output  MANT_W  normalised mantissa (MSB = hidden bit unless denormal/zero)
out_exp  output  EXP_W  adjusted biased exponent
out_zero  output  1  result is zero
out_denorm  output  1  result is denormal (out_exp = 0, MSB = 0)
out_ovf  output  1  exponent overflow; result is infinity
out_sticky  output  1  bit shifted out by carry right-shift

Behaviour:
- One clock domain; the asynchronous active-high reset is applied on rst and takes effect independently of clk.
- Reset drives state=IDLE, in_ready=1, and all out_* = 0, including out_valid.
- States are IDLE, SHIFT and DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE: when in_valid && in_ready, register the working mantissa M (MANT_W+1 bits) and exponent E, then go to SHIFT.
- SHIFT: evaluate once per cycle, in priority order:
  1. Carry set (M[MANT_W]=1): out_mant=M[MANT_W:1], out_sticky=M[0], out_exp=E+1. If E+1 == all-ones: out_mant=0, out_ovf=1. Go to DONE.
  2. M==0: out_mant=0, out_exp=0, out_zero=1. Go to DONE.
  3. Otherwise let lz = leading zeros of M[MANT_W-1:0] and s = min(lz, STEP, E>1 ? E-1 : 0). Set M<<=s and E-=s.
     - If M[MANT_W-1]=1 after the shift: present M, E. Go to DONE.
     - Else if E<=1 (no further shift allowed): present M, out_exp=0, out_denorm=1. Go to DONE.
     - Else remain in SHIFT.
- Input with E=0 and no carry is already denormal: s=0, output exp 0, out_denorm=1 (out_zero instead if M==0).
- Latency from accept edge to out_valid: max(1, ceil(min(lz, E-1)/STEP)) clock edges, with min 1. Carry, zero and lz=0 inputs take 1 edge.
- DONE: hold every out_* stable while out_ready=0. When out_ready=1, go to IDLE, clear out_valid and flags, and raise in_ready on the next cycle.
- One beat in flight at a time. No accept in the same cycle as an output handshake.
- in_* are ignored outside IDLE.
- Exponent arithmetic is EXP_W wide unsigned. The subtraction never wraps because of the E-1 clamp.
- Reset asserted mid-SHIFT or mid-DONE discards the beat immediately. No out_valid is produced for it.

Test Plan:
1. MANT_W=24, EXP_W=8, STEP=4. in_mant=0x0800000, exp=100 -> out_mant=0x800000, exp=100, no flags; out_valid 1 edge after accept.
2. in_mant=0x0040000 (lz=5), exp=100 -> out_mant=0x800000, exp=95; out_valid 2 edges after accept, in_ready=0 meanwhile.
3. in_mant=0x0000100 (lz=15), exp=10 -> shift limited to 9: out_mant=0x020000, exp=0, out_denorm=1.
4. in_mant=0x1000001, exp=100 -> out_mant=0x800000, exp=101, out_sticky=1. Same with exp=254 -> exp=255, mant=0, out_ovf=1.
5. in_mant=0, exp=77 -> out_zero=1, exp=0. Then hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0. Release -> one transfer, back to IDLE.
6. Assert rst during SHIFT of case 2 -> out_valid stays 0, in_ready=1 after release. A new beat processes correctly.

Source files
------------

// File: rtl/fp_normalizer_seq.sv
// fp_normalizer_seq: multi-cycle mantissa normaliser with carry right-shift, overflow to infinity,
// underflow to denormal and status flags, behind a valid/ready handshake.
module fp_normalizer_seq #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int STEP   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W:0]   in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_denorm,
  output logic              out_ovf,
  output logic              out_sticky
);
  localparam int LZ_W = $clog2(MANT_W + 1);
  localparam int SW   = (LZ_W > EXP_W ? LZ_W : EXP_W) + 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t            r_state, w_next;
  logic [MANT_W:0]   r_m, w_m, w_m_sh;
  logic [EXP_W-1:0]  r_e, w_e, w_e_sh, w_e_inc, w_e_lim;
  logic [LZ_W-1:0]   w_lz;
  logic [SW-1:0]     w_s0, w_s;
  logic [MANT_W-1:0] r_mant, w_mant;
  logic [EXP_W-1:0]  r_exp, w_exp;
  logic              r_zero, w_zero, r_den, w_den, r_ovf, w_ovf, r_sticky, w_sticky;
  always_comb begin
    w_lz = LZ_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++)
      if (r_m[i]) w_lz = LZ_W'(MANT_W - 1 - i);
  end
  // Shift is clamped so the exponent never drops below 1 while shifting.
  assign w_e_lim = (r_e > EXP_W'(1)) ? r_e - EXP_W'(1) : '0;
  assign w_s0    = (SW'(w_lz) < SW'(STEP)) ? SW'(w_lz) : SW'(STEP);
  assign w_s     = (SW'(w_e_lim) < w_s0) ? SW'(w_e_lim) : w_s0;
  assign w_m_sh  = r_m << w_s;
  assign w_e_sh  = r_e - EXP_W'(w_s);
  assign w_e_inc = r_e + EXP_W'(1);
  always_comb begin
    w_next   = r_state;
    w_m      = r_m;
    w_e      = r_e;
    w_mant   = r_mant;
    w_exp    = r_exp;
    w_zero   = r_zero;
    w_den    = r_den;
    w_ovf    = r_ovf;
    w_sticky = r_sticky;
    case (r_state)
      IDLE: if (in_valid) begin
        w_m    = in_mant;
        w_e    = in_exp;
        w_next = SHIFT;
      end
      SHIFT: if (r_m[MANT_W]) begin
        w_ovf    = &w_e_inc;
        w_mant   = (&w_e_inc) ? '0 : r_m[MANT_W:1];
        w_exp    = w_e_inc;
        w_sticky = r_m[0];
        w_next   = DONE;
      end else if (r_m == '0) begin
        w_mant = '0;
        w_exp  = '0;
        w_zero = 1'b1;
        w_next = DONE;
      end else begin
        w_m = w_m_sh;
        w_e = w_e_sh;
        if (w_m_sh[MANT_W-1]) begin
          w_mant = w_m_sh[MANT_W-1:0];
          w_exp  = w_e_sh;
          w_next = DONE;
        end else if (w_e_sh <= EXP_W'(1)) begin
          w_mant = w_m_sh[MANT_W-1:0];
          w_exp  = '0;
          w_den  = 1'b1;
          w_next = DONE;
        end
      end
      DONE: if (out_ready) begin
        w_zero   = 1'b0;
        w_den    = 1'b0;
        w_ovf    = 1'b0;
        w_sticky = 1'b0;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_m      <= '0;
      r_e      <= '0;
      r_mant   <= '0;
      r_exp    <= '0;
      r_zero   <= 1'b0;
      r_den    <= 1'b0;
      r_ovf    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_m      <= w_m;
      r_e      <= w_e;
      r_mant   <= w_mant;
      r_exp    <= w_exp;
      r_zero   <= w_zero;
      r_den    <= w_den;
      r_ovf    <= w_ovf;
      r_sticky <= w_sticky;
    end
  end
  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign out_mant   = r_mant;
  assign out_exp    = r_exp;
  assign out_zero   = r_zero;
  assign out_denorm = r_den;
  assign out_ovf    = r_ovf;
  assign out_sticky = r_sticky;
endmodule
